// File: rtl/rv_branch_unit.sv
// -----------------------------------------------------------------------------
// rv_branch_unit
//   Branch resolution and prediction unit for the RV core.
//   - Evaluates the six conditional branches directly on rs1/rs2, using both
//     signed and unsigned comparison.
//   - Owns a BHT_DEPTH-entry table of 2-bit saturating counters. The table
//     gives IF a combinational taken/not-taken prediction.
//   - Resolves the branch in EX and registers the outcome, the mispredict flag
//     and the redirect PC (1-cycle latency). It then trains the table.
//
// Ports
//   clk_i            core clock
//   rst_n_i          asynchronous active-low reset
//   if_pc_i          fetch PC for the prediction lookup
//   if_pred_taken_o  combinational prediction (MSB of the indexed counter)
//   ex_valid_i       EX holds a conditional branch this cycle
//   ex_pc_i          PC of the branch in EX
//   ex_rs1_i         operand rs1
//   ex_rs2_i         operand rs2
//   ex_funct3_i      branch funct3
//   ex_target_i      precomputed taken target (pc + imm)
//   ex_pred_taken_i  prediction carried down the pipe with this branch
//   flush_i          kill the branch in EX
//   res_valid_o      registered: resolution valid
//   res_taken_o      registered: actual outcome
//   mispredict_o     registered: outcome differs from the carried prediction
//   redirect_pc_o    registered: taken ? target : pc + 4
//   illegal_o        registered: one-cycle pulse for funct3 010/011
//   br_cnt_o         saturating count of resolved branches
//   mis_cnt_o        saturating count of mispredicted branches
// -----------------------------------------------------------------------------
module rv_branch_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             if_pred_taken_o,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic [XLEN-1:0]  ex_rs2_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic             flush_i,
  output logic             res_valid_o,
  output logic             res_taken_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  // Weakly not-taken is the reset value of every counter.
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

  // Branch history table: one 2-bit saturating counter per entry.
  logic [1:0] bht [BHT_DEPTH];

  logic [IDXW-1:0] if_idx;
  logic [IDXW-1:0] ex_idx;

  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken;
  logic            legal;
  logic            accept;
  logic            illegal_hit;
  logic            mispred;
  logic [XLEN-1:0] pc_plus4;
  logic [1:0]      bht_cur;
  logic [1:0]      bht_next;

  // Word-aligned PCs: bits [1:0] never select an entry. Bits above the index
  // alias onto the same counter.
  assign if_idx = if_pc_i[IDXW+1:2];
  assign ex_idx = ex_pc_i[IDXW+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDXW+2], if_pc_i[1:0],
                            ex_pc_i[XLEN-1:IDXW+2], ex_pc_i[1:0]};

  // The lookup reads the table as stored. A same-cycle update to the same
  // entry becomes visible on the following cycle only.
  assign if_pred_taken_o = bht[if_idx][1];

  // Compare the operands directly. This avoids waiting for an ALU subtract.
  assign eq  = (ex_rs1_i == ex_rs2_i);
  assign lt  = ($signed(ex_rs1_i) < $signed(ex_rs2_i));
  assign ltu = (ex_rs1_i < ex_rs2_i);

  // funct3 decode. 010 and 011 are not branch encodings.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (ex_funct3_i)
      3'b000: taken = eq;
      3'b001: taken = ~eq;
      3'b100: taken = lt;
      3'b101: taken = ~lt;
      3'b110: taken = ltu;
      3'b111: taken = ~ltu;
      3'b010,
      3'b011: legal = 1'b0;
    endcase
  end

  assign accept      = ex_valid_i & ~flush_i & legal;
  assign illegal_hit = ex_valid_i & ~flush_i & ~legal;
  assign mispred     = (taken != ex_pred_taken_i);
  assign pc_plus4    = ex_pc_i + XLEN'(4);

  // Saturating step of the counter for the branch being resolved.
  assign bht_cur = bht[ex_idx];

  always_comb begin
    bht_next = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
    end
  end

  // Table training. Only accepted branches train. An illegal or flushed
  // branch leaves the table untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CNT_WEAK_NT;
      end
    end else if (accept) begin
      bht[ex_idx] <= bht_next;
    end
  end

  // Resolution outputs. The valid, mispredict and illegal flags are pulses.
  // The outcome and the redirect PC keep the last resolved branch so that
  // consumers can sample them late.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_o   <= 1'b0;
      res_taken_o   <= 1'b0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
      illegal_o     <= 1'b0;
    end else begin
      res_valid_o  <= accept;
      mispredict_o <= accept & mispred;
      illegal_o    <= illegal_hit;
      if (accept) begin
        res_taken_o   <= taken;
        redirect_pc_o <= taken ? ex_target_i : pc_plus4;
      end
    end
  end

  // Statistics counters. Both stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      br_cnt_o  <= '0;
      mis_cnt_o <= '0;
    end else if (accept) begin
      if (br_cnt_o != '1) br_cnt_o <= br_cnt_o + CNT_W'(1);
      if (mispred && (mis_cnt_o != '1)) mis_cnt_o <= mis_cnt_o + CNT_W'(1);
    end
  end

endmodule
